// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Holds the program counter, reads
//            instruction memory and presents the fetched word (MBR) to the
//            decode stage with a valid/ready handshake. Supports PC redirect
//            and halt.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
   parameter int                ADDR_W   = 8,
   parameter int                DATA_W   = 16,
   parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
   input  logic              CLK,
   input  logic              RST_N,
   output logic              MEM_REQ,
   output logic [ADDR_W-1:0] MEM_ADDR,
   input  logic [DATA_W-1:0] MEM_RDATA,
   input  logic              MEM_ACK,
   output logic [DATA_W-1:0] MBR,
   output logic              MBR_VALID,
   input  logic              DEC_READY,
   input  logic              PC_LOAD,
   input  logic [ADDR_W-1:0] PC_TARGET,
   input  logic              HALT,
   output logic [ADDR_W-1:0] PC,
   output logic              BUSY
);

   typedef enum logic [1:0] {
      S_START  = 2'd0,
      S_FETCH  = 2'd1,
      S_HOLD   = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0]   mbr_q, mbr_d;
   logic                mbr_valid_q, mbr_valid_d;
   logic                redir_q, redir_d;     // redirect arrived while a read was outstanding
   logic [ADDR_W-1:0]   target_q, target_d;   // where to go once that read completes

   // State and datapath registers, asynchronously cleared
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= S_START;
         pc_q        <= PC_RESET;
         mbr_q       <= '0;
         mbr_valid_q <= 1'b0;
         redir_q     <= 1'b0;
         target_q    <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         mbr_q       <= mbr_d;
         mbr_valid_q <= mbr_valid_d;
         redir_q     <= redir_d;
         target_q    <= target_d;
      end
   end

   // Next-state logic: request lifecycle, redirect bookkeeping and handshake
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      mbr_d       = mbr_q;
      mbr_valid_d = mbr_valid_q;
      redir_d     = redir_q;
      target_d    = target_q;

      case (state_q)
         S_START: begin
            state_d = HALT ? S_HALTED : S_FETCH;
         end

         S_FETCH: begin
            // HALT is not looked at here: an issued read always completes.
            if (MEM_ACK) begin
               if (PC_LOAD || redir_q) begin
                  // Word belongs to the abandoned path; drop it and refetch.
                  pc_d    = PC_LOAD ? PC_TARGET : target_q;
                  redir_d = 1'b0;
               end else begin
                  mbr_d       = MEM_RDATA;
                  mbr_valid_d = 1'b1;
                  pc_d        = pc_q + ADDR_W'(1);
                  state_d     = S_HOLD;
               end
            end else if (PC_LOAD) begin
               redir_d  = 1'b1;
               target_d = PC_TARGET;
            end
         end

         S_HOLD: begin
            if (PC_LOAD) begin
               // Flush the held word; it is on the wrong path.
               mbr_valid_d = 1'b0;
               mbr_d       = '0;
               pc_d        = PC_TARGET;
               state_d     = HALT ? S_HALTED : S_FETCH;
            end else if (DEC_READY) begin
               mbr_valid_d = 1'b0;
               state_d     = HALT ? S_HALTED : S_FETCH;
            end
         end

         S_HALTED: begin
            if (PC_LOAD) begin
               pc_d = PC_TARGET;
            end
            if (!HALT) begin
               state_d = S_FETCH;
            end
         end

         default: begin
            state_d = S_START;
         end
      endcase
   end

   // Memory-side signals decode straight from state so they drop with reset
   assign MEM_REQ   = (state_q == S_FETCH);
   assign BUSY      = (state_q == S_FETCH);
   assign MEM_ADDR  = pc_q;
   assign PC        = pc_q;
   assign MBR       = mbr_q;
   assign MBR_VALID = mbr_valid_q;

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the decode stage. Holds the program counter, issues a read to instruction memory, and captures the returned 16-bit word into MBR. Presents MBR with a valid/ready handshake to decode, which splits it into IDEN[13:12], OPCODE[11:8] and ADDRESS[7:0]. Supports a PC redirect for jumps and branches, and a halt.

Parameters:
ADDR_W, 8, width of PC / MEM_ADDR / PC_TARGET (matches decode ADDRESS width)
DATA_W, 16, instruction word width (MBR width)
PC_RESET, 0, PC value loaded on reset

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
MEM_REQ  output  1  read request; high for the whole FETCH state
MEM_ADDR  output  ADDR_W  read address, equal to PC while MEM_REQ=1
MEM_RDATA  input  DATA_W  read data, sampled only when MEM_ACK=1
MEM_ACK  input  1  single-cycle read completion; may arrive in the same cycle MEM_REQ rises
MBR  output  DATA_W  fetched instruction word, feeds decode
MBR_VALID  output  1  MBR holds an unconsumed instruction
DEC_READY  input  1  decode/control accepts MBR this cycle
PC_LOAD  input  1  redirect request (one-cycle pulse)
PC_TARGET  input  ADDR_W  redirect address, sampled when PC_LOAD=1
HALT  input  1  level; stop issuing new fetches
PC  output  ADDR_W  current program counter
BUSY  output  1  high when a memory request is outstanding (state FETCH)

Behaviour:
- Reset (RST_N=0, asynchronous): state=START, PC=PC_RESET, MBR=0, MBR_VALID=0, redirect-pending flag=0, stored target=0. MEM_REQ=0, BUSY=0.
- All state and outputs are registered, except MEM_REQ, BUSY and MEM_ADDR. These are decoded from state and PC.
- States: START, FETCH, HOLD, HALTED.
- START: on the next edge, go to HALTED if HALT=1, else FETCH.
- FETCH: MEM_REQ=1, MEM_ADDR=PC. MEM_REQ stays high and MEM_ADDR stays stable until MEM_ACK.
  - On an edge with MEM_ACK=1 and no redirect pending (no PC_LOAD this cycle, flag=0): MBR<=MEM_RDATA, MBR_VALID<=1, PC<=PC+1 mod 2^ADDR_W (0xFF wraps to 0x00), go to HOLD.
  - On an edge with MEM_ACK=1 and a redirect pending or PC_LOAD=1: discard the data, MBR_VALID stays 0, PC<=target (the PC_TARGET of this cycle if PC_LOAD=1, else the stored target), clear the flag, stay in FETCH. A new request is issued the next cycle.
  - On an edge with PC_LOAD=1 and MEM_ACK=0: set the flag and store PC_TARGET. The outstanding request is never withdrawn. A later PC_LOAD overwrites the stored target.
- HOLD: MBR_VALID=1 and MBR stable until the handshake.
  - PC_LOAD=1 takes priority: MBR_VALID<=0, PC<=PC_TARGET, go to FETCH (or HALTED if HALT=1). MBR is flushed.
  - Else DEC_READY=1: MBR_VALID<=0, go to HALTED if HALT=1, else FETCH.
  - Else stay in HOLD.
- HALTED: no request. PC_LOAD=1 updates PC. Go to FETCH on the first edge with HALT=0.
- HALT is ignored in FETCH, because the outstanding request must complete. It takes effect when leaving HOLD or START.
- Latency: if MEM_ACK arrives in the cycle MEM_REQ rises (cycle N), MBR_VALID=1 in N+1. If DEC_READY=1 in N+1, MEM_REQ for the next PC rises in N+2. Peak throughput is one instruction every 2 cycles.
- MEM_ACK outside FETCH is ignored.

Test Plan:
- Reset then sequential fetch: memory returns 0x1203 at addr 0x00 and 0x2405 at 0x01 with same-cycle ACK, DEC_READY=1 -> MBR=0x1203 in cycle 2, then 0x2405 two cycles later. PC steps 0x00→0x01→0x02 and MEM_ADDR tracks it.
- Decode backpressure: DEC_READY=0 for 5 cycles after MBR=0x1203 -> MBR_VALID=1 and MBR constant, MEM_REQ=0 throughout. After DEC_READY=1, the next request goes to addr 0x01.
- Slow memory plus redirect: ACK delayed 3 cycles, PC_LOAD with target 0x40 in cycle 1 of the wait -> MEM_ADDR stays 0x00 until ACK. The returned word is dropped with MBR_VALID=0, and the next request goes to 0x40.
- Redirect in HOLD: MBR_VALID=1, PC_LOAD=1 with target 0x80 and DEC_READY=1 in the same cycle -> flush, MBR_VALID=0, next MEM_ADDR=0x80.
- Wrap and halt: PC=0xFF, fetch completes -> PC=0x00. HALT=1 before DEC_READY -> enters HALTED with no MEM_REQ. HALT=0 -> fetch resumes at 0x00.
- Async reset mid-FETCH (RST_N low while MEM_REQ=1) -> MEM_REQ, MBR_VALID and BUSY drop immediately without a clock edge, and PC=PC_RESET.
